// File: rtl/inv_sbox_seq_if.sv
// Handshake and data bundle for the sequential InvSubBytes engine.
// The master issues start/s_in and the slave returns busy/done/s_o.
interface inv_sbox_seq_if;
    logic         start;
    logic [127:0] s_in;
    logic         busy;
    logic         done;
    logic [127:0] s_o;

    modport master (output start, s_in, input busy, done, s_o);
    modport slave  (input start, s_in, output busy, done, s_o);
endinterface

// File: rtl/inv_sbox_seq.sv
// Byte-serial AES InvSubBytes: one inverse S-box lookup per cycle, 16 cycles per
// 128-bit state, result published in a single DONE cycle.
module inv_sbox_seq (
    input logic           clk,
    input logic           rst,
    inv_sbox_seq_if.slave bus
);
    // FIPS-197 inverse S-box; entry x sits at bits [2047-8x -: 8] (row 0 in the MSBs).
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t       state;
    logic [127:0] sh;
    logic [127:0] res;
    logic [3:0]   cnt;
    logic [7:0]   sub_byte;

    function automatic logic [7:0] inv_s(input logic [7:0] x);
        logic [10:0] idx;
        idx = 11'd2047 - {x, 3'b000};
        return INV_SBOX[idx -: 8];
    endfunction

    // The only lookup: always the lowest unprocessed byte of the capture register.
    assign sub_byte = inv_s(sh[7:0]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            sh       <= '0;
            res      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.s_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        sh       <= bus.s_in;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= SUB;
                    end
                end
                SUB: begin
                    sh  <= {8'h00, sh[127:8]};
                    res <= {sub_byte, res[127:8]};
                    cnt <= cnt + 4'd1;
                    // After 16 right-shifts byte 0 lands back at res[7:0]: order is preserved.
                    if (cnt == 4'd15) begin
                        bus.s_o  <= {sub_byte, res[127:8]};
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        sh       <= bus.s_in;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= SUB;
                    end else begin
                        state    <= IDLE;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inv_sbox_seq.sv
// Scoreboard bench for inv_sbox_seq; reference inverse S-box is derived from
// GF(2^8) inversion plus the AES affine map, then inverted as a lookup array.
module tb_inv_sbox_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inv_sbox_seq_if bif ();
    inv_sbox_seq dut (.clk(clk), .rst(rst), .bus(bif));

    int errors = 0;
    int checks = 0;
    logic [127:0] exp_q[$];
    logic [7:0] sb [256];
    logic [7:0] isb[256];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = 8'h00;
        for (int y = 1; y < 256; y++)
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) b = 8'(y);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] v);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = isb[v[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && bif.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got s_o %h with no pass outstanding", bif.s_o);
            end else begin
                chk("s_o", bif.s_o, exp_q.pop_front());
            end
        end
    end

    task automatic do_pass(input logic [127:0] v, input logic [127:0] e, input bit noise);
        int lat;
        int bc;
        lat = 0;
        bc  = 0;
        bif.s_in  = v;
        bif.start = 1'b1;
        exp_q.push_back(e);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bif.busy) bc++;
            if (bif.done) begin
                lat = n;
                break;
            end
            if (noise && n <= 15) begin
                bif.start = 1'($urandom_range(0, 1));
                bif.s_in  = rnd128();
            end else begin
                bif.start = 1'b0;
            end
        end
        bif.start = 1'b0;
        chk("latency", 128'(lat), 128'd17);
        chk("busy_cycles", 128'(bc), 128'd16);
        @(negedge clk);
        chk("done_width", 128'(bif.done), 128'd0);
        chk("s_o_hold", bif.s_o, e);
    endtask

    task automatic run_stream();
        logic [127:0] v;
        int dones;
        dones = 0;
        v = rnd128();
        bif.s_in  = v;
        bif.start = 1'b1;
        exp_q.push_back(model(v));
        for (int k = 1; k <= 75; k++) begin
            @(negedge clk);
            if (bif.done) begin
                dones++;
                chk("stream_period", 128'(k % 17), 128'd0);
            end
            if (k % 17 == 0 && k < 52) begin
                v = rnd128();
                bif.s_in = v;
                exp_q.push_back(model(v));
            end else begin
                bif.s_in = rnd128();
            end
            if (k >= 52) bif.start = 1'b0;
        end
        chk("stream_count", 128'(dones), 128'd4);
    endtask

    task automatic run_reset_abort();
        int dn;
        dn = 0;
        bif.s_in  = rnd128();
        bif.start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bif.start = 1'b0;
        end
        // Reset lands on the 9th edge with start also high: reset must win.
        rst       = 1'b0;
        bif.start = 1'b1;
        @(negedge clk);
        chk("abort_busy", 128'(bif.busy), 128'd0);
        chk("abort_done", 128'(bif.done), 128'd0);
        chk("abort_s_o", bif.s_o, 128'd0);
        rst       = 1'b1;
        bif.start = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bif.done) dn++;
        end
        chk("abort_no_done", 128'(dn), 128'd0);
        bif.s_in = rnd128();
        do_pass(bif.s_in, model(bif.s_in), 1'b0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bif.s_in = rnd128();
        do_pass(bif.s_in, model(bif.s_in), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] v, e;
        rst       = 1'b0;
        bif.start = 1'b0;
        bif.s_in  = '0;
        for (int x = 0; x < 256; x++) begin
            sb[x] = fwd_sbox(8'(x));
            isb[sb[x]] = 8'(x);
        end
        repeat (3) @(negedge clk);
        chk("reset_busy", 128'(bif.busy), 128'd0);
        chk("reset_done", 128'(bif.done), 128'd0);
        chk("reset_s_o", bif.s_o, 128'd0);
        rst = 1'b1;
        @(negedge clk);

        do_pass(128'h000102030405060708090a0b0c0d0e0f,
                128'h52096ad53036a538bf40a39e81f3d7fb, 1'b0);
        do_pass({16{8'h63}}, 128'h0, 1'b0);
        do_pass({16{8'h16}}, {16{8'hff}}, 1'b0);

        for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < 16; k++) begin
                v[8*k +: 8] = sb[16*j + k];
                e[8*k +: 8] = 8'(16*j + k);
            end
            do_pass(v, e, 1'b0);
        end

        for (int i = 0; i < 6; i++) begin
            v = rnd128();
            do_pass(v, model(v), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            v = rnd128();
            do_pass(v, model(v), 1'b1);
        end

        run_stream();
        run_reset_abort();

        repeat (30) @(negedge clk);
        chk("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
